decode_sequencer: RTL

//  Registered decode stage between fetch and execute. Accepts instructions over a valid/ready

---
 rtl/decode_pkg.sv | 41 ++++
 rtl/imm_decode.sv | 96 +++++++++
 rtl/decode_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared types for the decode stage: immediate-format select, opcode constants,
// control strobe bundle and skid occupancy states.
package decode_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_sel_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic branch;
        logic jump;
        logic alu_src;
        logic illegal;
    } ctrl_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_state_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational opcode classifier and immediate generator.
// DECODE_UJ_EN enables LUI/AUIPC (U) and JAL (J); otherwise those opcodes are illegal.
module imm_decode
    import decode_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output imm_sel_e        imm_sel,
    output ctrl_t           ctrl
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm32;

    always_comb begin
        imm_i = {{20{instr[31]}}, instr[31:20]};
        imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        imm_u = {instr[31:12], 12'b0};
        imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    end

    always_comb begin
        imm_sel = IMM_NONE;
        ctrl    = '0;
        case (instr[6:0])
            OPC_LOAD: begin
                imm_sel        = IMM_I;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OPC_OP_IMM: begin
                imm_sel        = IMM_I;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OPC_JALR: begin
                imm_sel        = IMM_I;
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OPC_STORE: begin
                imm_sel        = IMM_S;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OPC_BRANCH: begin
                imm_sel        = IMM_B;
                ctrl.branch    = 1'b1;
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
            end
            OPC_SYSTEM: begin
                imm_sel        = IMM_I;
            end
`ifdef DECODE_UJ_EN
            OPC_LUI, OPC_AUIPC: begin
                imm_sel        = IMM_U;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            OPC_JAL: begin
                imm_sel        = IMM_J;
                ctrl.reg_write = 1'b1;
                ctrl.jump      = 1'b1;
            end
`endif
            default: begin
                ctrl.illegal   = 1'b1;
            end
        endcase
    end

    // Every format is computed unconditionally; the select alone decides what leaves.
    always_comb begin
        case (imm_sel)
            IMM_I:   imm32 = imm_i;
            IMM_S:   imm32 = imm_s;
            IMM_B:   imm32 = imm_b;
            IMM_U:   imm32 = imm_u;
            IMM_J:   imm32 = imm_j;
            default: imm32 = '0;
        endcase
        imm = XLEN'($signed(imm32));
    end

endmodule

// File: rtl/decode_sequencer.sv
// Registered decode stage with output register plus one skid entry and flush.
// Optional U/J decode is controlled by DECODE_UJ_EN inside imm_decode.
module decode_sequencer
    import decode_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SKID_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_sel,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_jump,
    output logic            out_alu_src,
    output logic            out_illegal
);

    if (SKID_DEPTH != 2) begin : g_depth_check
        $error("decode_sequencer supports SKID_DEPTH == 2 only");
    end

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        imm_sel_e        sel;
        ctrl_t           ctrl;
    } entry_t;

    occ_state_e state_q, state_d;
    entry_t     out_q, out_d;
    entry_t     skid_q, skid_d;
    entry_t     new_entry;
    logic       out_valid_q, out_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       accept;
    logic       retire;

    logic [XLEN-1:0] dec_imm;
    imm_sel_e        dec_sel;
    ctrl_t           dec_ctrl;

    imm_decode #(
        .XLEN (XLEN)
    ) u_imm_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .imm_sel (dec_sel),
        .ctrl    (dec_ctrl)
    );

    always_comb begin
        new_entry.instr = in_instr;
        new_entry.pc    = in_pc;
        new_entry.imm   = dec_imm;
        new_entry.sel   = dec_sel;
        new_entry.ctrl  = dec_ctrl;
    end

    assign accept = in_valid & in_ready_q;
    assign retire = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            out_d   = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        out_d   = new_entry;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && retire) begin
                        out_d   = new_entry;
                    end else if (accept) begin
                        skid_d  = new_entry;
                        state_d = ST_FULL;
                    end else if (retire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (retire) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    always_comb begin
        in_ready      = in_ready_q;
        out_valid     = out_valid_q;
        out_instr     = out_q.instr;
        out_pc        = out_q.pc;
        out_imm       = out_q.imm;
        out_imm_sel   = out_q.sel;
        out_reg_write = out_q.ctrl.reg_write;
        out_mem_read  = out_q.ctrl.mem_read;
        out_mem_write = out_q.ctrl.mem_write;
        out_branch    = out_q.ctrl.branch;
        out_jump      = out_q.ctrl.jump;
        out_alu_src   = out_q.ctrl.alu_src;
        out_illegal   = out_q.ctrl.illegal;
    end

endmodule
